up_run_monitor: RTL

//  Synthesizable run controller and monitor for the uP core. Generates a stretched core reset,

---
 rtl/up_run_monitor_pkg.sv | 26 ++
 rtl/up_run_monitor_trace_buf.sv | 74 +++++++
 rtl/up_run_monitor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/up_run_monitor_pkg.sv
// Shared types and defaults for the uP run controller/monitor.
//   run_state_e : controller states (reset hold, running, halted, timed out)
//   DEF_*       : default parameter values used by up_run_monitor
//   cnt_width() : bits needed to hold a counter that reaches max_val
package up_run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_RUN      = 2'd1,
    ST_HALTED   = 2'd2,
    ST_TIMEOUT  = 2'd3
  } run_state_e;

  localparam int unsigned DEF_PC_W        = 10;
  localparam int unsigned DEF_INSTR_W     = 16;
  localparam int unsigned DEF_DEPTH       = 16;
  localparam int unsigned DEF_RST_CYCLES  = 2;
  localparam int unsigned DEF_MAX_CYCLES  = 40;
  localparam int unsigned DEF_HALT_STABLE = 4;
  localparam int unsigned DEF_CNT_W       = 16;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/up_run_monitor_trace_buf.sv
// Circular trace RAM of the most recent DEPTH fetched {pc, instr} words.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : synchronous clear (restart); empties the buffer
//   wr_en     : append wr_data at the write pointer, overwriting the oldest
//   wr_data   : {pc, instr} to store
//   rd_idx    : 0 = newest entry, 1 = previous, ...
//   rd_data   : registered read data, 0 when rd_idx >= count
//   count     : number of valid entries, saturates at DEPTH
module up_run_monitor_trace_buf
  import up_run_monitor_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_PC_W + DEF_INSTR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] COUNT_FULL = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [IDX_W-1:0]  rd_addr;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    // Newest entry sits just behind the write pointer; wraps mod DEPTH.
    rd_addr   = wr_ptr_q - IDX_W'(1) - rd_idx;
    rd_data_d = ({1'b0, rd_idx} < count_q) ? mem_q[rd_addr] : '0;
    if (clr) begin
      wr_ptr_d  = '0;
      count_d   = '0;
      rd_data_d = '0;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + IDX_W'(1);
      if (count_q != COUNT_FULL) begin
        count_d = count_q + (IDX_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset: count hides stale entries.
  always_ff @(posedge clk) begin
    if (wr_en && !clr && !rst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/up_run_monitor.sv
// Run controller and monitor for the uP core: stretches the core reset,
// counts RUN cycles, declares a halt on a PC self-loop or a timeout on the
// cycle budget, and keeps a readable trace of recently fetched words.
//   clk, Reset    : clock, synchronous active-high reset
//   restart       : pulse, re-run the program from reset (clears trace)
//   pc_in         : uP fetch address
//   instr_in      : instruction fetched at pc_in
//   trace_rd_idx  : trace index, 0 = most recent
//   core_reset    : reset to the uP core (high only while holding reset)
//   running       : controller is in RUN
//   halted        : sticky halt flag
//   timed_out     : sticky timeout flag
//   cycle_count   : RUN cycles elapsed (saturating)
//   halt_pc       : PC at which the halt was declared
//   trace_count   : valid trace entries, saturates at DEPTH
//   trace_rd_data : {pc, instr} at trace_rd_idx, one cycle latency
module up_run_monitor
  import up_run_monitor_pkg::*;
#(
  parameter int unsigned PC_W        = DEF_PC_W,
  parameter int unsigned INSTR_W     = DEF_INSTR_W,
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned MAX_CYCLES  = DEF_MAX_CYCLES,
  parameter int unsigned HALT_STABLE = DEF_HALT_STABLE,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      Reset,
  input  logic                      restart,
  input  logic [PC_W-1:0]           pc_in,
  input  logic [INSTR_W-1:0]        instr_in,
  input  logic [$clog2(DEPTH)-1:0]  trace_rd_idx,
  output logic                      core_reset,
  output logic                      running,
  output logic                      halted,
  output logic                      timed_out,
  output logic [CNT_W-1:0]          cycle_count,
  output logic [PC_W-1:0]           halt_pc,
  output logic [$clog2(DEPTH):0]    trace_count,
  output logic [PC_W+INSTR_W-1:0]   trace_rd_data
);

  localparam int unsigned HOLD_W = cnt_width(RST_CYCLES);
  localparam int unsigned STB_W  = cnt_width(HALT_STABLE);

  run_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
  logic [STB_W-1:0]  stable_q, stable_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic              halted_q, halted_d;
  logic              timed_out_q, timed_out_d;
  logic [PC_W-1:0]   halt_pc_q, halt_pc_d;

  logic              same_pc;
  logic              trace_wr_en;
  logic              trace_clr;

  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    cycle_count_d = cycle_count_q;
    stable_d      = stable_q;
    pc_d          = pc_q;
    pc_valid_d    = pc_valid_q;
    halted_d      = halted_q;
    timed_out_d   = timed_out_q;
    halt_pc_d     = halt_pc_q;
    trace_wr_en   = 1'b0;
    trace_clr     = restart;
    same_pc       = pc_valid_q && (pc_in == pc_q);

    unique case (state_q)
      ST_RST_HOLD: begin
        if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
          hold_cnt_d = '0;
          state_d    = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        cycle_count_d = (cycle_count_q == '1) ? cycle_count_q
                                               : cycle_count_q + CNT_W'(1);
        pc_d          = pc_in;
        pc_valid_d    = 1'b1;
        stable_d      = same_pc ? stable_q + STB_W'(1) : '0;
        trace_wr_en   = !same_pc;
        // Halt is checked first so a halt landing on the budget cycle wins.
        if (same_pc && stable_d == STB_W'(HALT_STABLE)) begin
          state_d   = ST_HALTED;
          halted_d  = 1'b1;
          halt_pc_d = pc_in;
        end else if (cycle_count_d == CNT_W'(MAX_CYCLES)) begin
          state_d     = ST_TIMEOUT;
          timed_out_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (restart) begin
      state_d       = ST_RST_HOLD;
      hold_cnt_d    = '0;
      cycle_count_d = '0;
      stable_d      = '0;
      pc_d          = '0;
      pc_valid_d    = 1'b0;
      halted_d      = 1'b0;
      timed_out_d   = 1'b0;
      halt_pc_d     = '0;
      trace_wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= ST_RST_HOLD;
      hold_cnt_q    <= '0;
      cycle_count_q <= '0;
      stable_q      <= '0;
      pc_q          <= '0;
      pc_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      timed_out_q   <= 1'b0;
      halt_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      cycle_count_q <= cycle_count_d;
      stable_q      <= stable_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      halted_q      <= halted_d;
      timed_out_q   <= timed_out_d;
      halt_pc_q     <= halt_pc_d;
    end
  end

  up_run_monitor_trace_buf #(
    .DEPTH  (DEPTH),
    .DATA_W (PC_W + INSTR_W)
  ) u_trace_buf (
    .clk     (clk),
    .rst     (Reset),
    .clr     (trace_clr),
    .wr_en   (trace_wr_en),
    .wr_data ({pc_in, instr_in}),
    .rd_idx  (trace_rd_idx),
    .rd_data (trace_rd_data),
    .count   (trace_count)
  );

  assign core_reset  = (state_q == ST_RST_HOLD);
  assign running     = (state_q == ST_RUN);
  assign halted      = halted_q;
  assign timed_out   = timed_out_q;
  assign cycle_count = cycle_count_q;
  assign halt_pc     = halt_pc_q;

endmodule
